serial_tx_buffered: RTL and testbench
=====================================

// Module: serial_tx_buffered
// PURPOSE
//   Parametrised UART transmitter with an input FIFO. Configurable data width, parity and stop bits.
//   Serialises queued words LSB-first onto tx. Sends back-to-back frames with no idle gap while the FIFO holds data.
//   Sits between the miner result/status logic and the host serial pin.
//   Producers can burst words without waiting out each frame.
// PARAMETERS
//   CLK_PER_BIT  50  clk cycles per serial bit; must be >= 2
//   DATA_BITS    8   data bits per frame; legal range 5..9
//   PARITY       0   0 = none, 1 = odd, 2 = even (encodings from serial_pkg)
//   STOP_BITS    1   stop bits per frame; 1 or 2
//   FIFO_DEPTH   4   FIFO words; power of two, >= 2
// PORTS
//   clk         in   1                      system clock, rising edge
//   rst         in   1                      asynchronous reset, active-high
//   data        in   DATA_BITS              word to queue
//   new_data    in   1                      push request; accepted only when ready=1
//   ready       out  1                      FIFO not full
//   tx          out  1                      serial line, registered output, idle high
//   busy        out  1                      frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1   words currently queued
//   overflow    out  1                      1-cycle pulse when new_data=1 and ready=0; the word is dropped
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - tx=1, busy=0, ready=1, fifo_count=0, overflow=0, state=IDLE.
//     - FIFO is flushed.
//     - Mid-frame reset drives tx high immediately; the partial frame is abandoned.
//   Push: occurs on the rising edge where new_data && ready.
//     - Push and pop in the same cycle leave fifo_count unchanged.
//     - ready=0 exactly when fifo_count==FIFO_DEPTH.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE | START.
//     - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift reg, compute the parity bit, go to START.
//     - START: tx=0 for CLK_PER_BIT cycles.
//     - DATA: tx=shift[bit_ctr], LSB first, CLK_PER_BIT cycles per bit. Leave after bit DATA_BITS-1.
//     - PARITY: present only when PARITY!=0.
//         odd:  bit = ~^data (total ones odd)
//         even: bit = ^data
//     - STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles. At the last cycle:
//         FIFO non-empty: pop and go straight to START (zero gap).
//         otherwise: go to IDLE.
//   Latency: for a push at edge E0 into an idle block, tx falls after edge E0+2.
//   Frame length: CLK_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exactly.
//   Counters:
//     - bit counter width: $clog2(CLK_PER_BIT); clears on every bit boundary; no wrap past CLK_PER_BIT-1.
//     - bit index width: $clog2(DATA_BITS+1).
//   busy = (state!=IDLE) | (fifo_count!=0). busy deasserts the cycle after the last stop-bit cycle of the final frame.
//   The FIFO content of a word does not change after it is pushed. Input data is not required to be held.
//   Illegal parameter values are caught by an elaboration-time check.
// STRUCTURE
//   serial_pkg:
//     - PARITY_NONE/ODD/EVEN constants.
//     - FSM state encoding (3 bits: IDLE, START, DATA, PARITY, STOP).
//   Sub-module sync_fifo:
//     - parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty.
//     - async reset; first-word-fall-through dout.
//   Top level contains the FSM, shift register, counters and the tx/busy/overflow registers.
// TESTING (bench uses CLK_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
//   1. PARITY=0, STOP_BITS=1, push 0xA5 when idle:
//      - tx low 2 cycles after the push edge.
//      - bit sequence 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), 4 cycles each, 40 cycles total.
//      - busy falls after that.
//   2. PARITY=2 (even), push 0xA5 -> parity bit 0. PARITY=1 (odd) -> parity bit 1. STOP_BITS=2 -> stop high 8 cycles.
//   3. Six pushes on consecutive cycles from idle:
//      - 5 accepted; ready falls after the 5th push; 6th dropped with overflow=1 for one cycle.
//      - 5 frames emitted back-to-back with no idle cycle between stop and the next start.
//   4. Push on the same cycle as the STOP-end pop with fifo_count=2: fifo_count stays 2; words emitted in push order.
//   5. rst asserted mid-DATA of a frame with 3 words queued:
//      - tx=1 and fifo_count=0 without waiting for a clock edge.
//      - after release no frame is sent until a new push.
//   6. DATA_BITS=5, push 5'h13 -> tx 0,1,1,0,0,1,1 (start, data LSB first, stop); the upper bits of data are never sent.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the buffered serial transmitter: parity encodings and FSM states.
package serial_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/serial_tx_buffered.sv
// UART transmitter fed by a FIFO; emits queued words LSB-first, back-to-back while data is queued.
module serial_tx_buffered
  import serial_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 50,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        data,
  input  logic                        new_data,
  output logic                        ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned CTR_W = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (CLK_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("serial_tx_buffered: illegal parameter combination");
  end

  tx_state_e            r_state, w_state_nxt;
  logic [CTR_W-1:0]     r_clk_ctr, w_clk_ctr_nxt;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_ovf, w_ovf_nxt;

  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic [CNT_W-1:0]     w_fifo_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_bit_end;
  logic                 w_par_calc;

  assign w_push     = new_data & ~w_fifo_full;
  assign w_bit_end  = (r_clk_ctr == CTR_W'(CLK_PER_BIT - 1));
  assign w_par_calc = (PARITY == PARITY_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_clk_ctr <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_ctr <= w_clk_ctr_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_ctr_nxt = r_clk_ctr;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_dout;
          w_par_nxt     = w_par_calc;
          w_clk_ctr_nxt = '0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_clk_ctr_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_clk_ctr_nxt = r_clk_ctr + CTR_W'(1);
        end
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end) begin
          w_clk_ctr_nxt = '0;
          w_shift_nxt   = r_shift >> 1;
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_clk_ctr_nxt = r_clk_ctr + CTR_W'(1);
        end
      end
      ST_PARITY: begin
        w_tx_nxt = r_par;
        if (w_bit_end) begin
          w_clk_ctr_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_STOP;
        end else begin
          w_clk_ctr_nxt = r_clk_ctr + CTR_W'(1);
        end
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          w_clk_ctr_nxt = '0;
          if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
            w_bit_idx_nxt = '0;
            // Zero-gap chaining: the next word is popped on the last stop cycle.
            if (!w_fifo_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_fifo_dout;
              w_par_nxt   = w_par_calc;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_clk_ctr_nxt = r_clk_ctr + CTR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_count_nxt = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_busy_nxt  = (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
    w_ready_nxt = (w_count_nxt != CNT_W'(FIFO_DEPTH));
    w_ovf_nxt   = new_data & w_fifo_full;
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign ready      = r_ready;
  assign overflow   = r_ovf;
  assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Bench for serial_tx_buffered: frame-content vectors over four configurations plus a
// schedule-based reference model of instance u0 (8N1) under directed and random pushes.
module tb_serial_tx_buffered;

  localparam int CPB = 4;
  localparam int FRM = 40;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [3:0] nd;
  logic [3:0] w_tx;
  logic [3:0] w_busy;
  logic [3:0] rdy;
  logic [3:0] ovf;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  int checks   = 0;
  int failures = 0;

  serial_tx_buffered #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .data(data_in), .new_data(nd[0]), .ready(rdy[0]), .tx(w_tx[0]),
    .busy(w_busy[0]), .fifo_count(cnt0), .overflow(ovf[0]));
  serial_tx_buffered #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .data(data_in), .new_data(nd[1]), .ready(rdy[1]), .tx(w_tx[1]),
    .busy(w_busy[1]), .fifo_count(cnt1), .overflow(ovf[1]));
  serial_tx_buffered #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .data(data_in), .new_data(nd[2]), .ready(rdy[2]), .tx(w_tx[2]),
    .busy(w_busy[2]), .fifo_count(cnt2), .overflow(ovf[2]));
  serial_tx_buffered #(.CLK_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .data(data_in[4:0]), .new_data(nd[3]), .ready(rdy[3]), .tx(w_tx[3]),
    .busy(w_busy[3]), .fifo_count(cnt3), .overflow(ovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of u0: each accepted word gets a start edge = max(push+2, line free).
  int         m_push[$];
  int         m_start[$];
  logic [7:0] m_word[$];
  int         n;
  int         line_free;
  int         m_st;
  logic       m_rdy_b;
  logic       m_ovf;

  function automatic int cnt_at(int t);
    int c = 0;
    foreach (m_push[i]) if (m_push[i] <= t && m_start[i] - 1 > t) c++;
    return c;
  endfunction

  function automatic logic busy_at(int t);
    if (cnt_at(t) > 0) return 1'b1;
    foreach (m_start[i]) if (t >= m_start[i] - 1 && t < m_start[i] - 1 + FRM) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic tx_at(int t);
    logic [9:0] fb;
    logic [3:0] k;
    foreach (m_start[i]) begin
      if (t >= m_start[i] && t < m_start[i] + FRM) begin
        fb = {1'b1, m_word[i], 1'b0};
        k  = 4'((t - m_start[i]) / CPB);
        return fb[k];
      end
    end
    return 1'b1;
  endfunction

  always begin
    @(posedge clk);
    if (rst) begin
      m_push.delete(); m_start.delete(); m_word.delete();
      n = 0;
      line_free = 0;
    end else begin
      n++;
      m_rdy_b = (cnt_at(n - 1) < 4);
      m_ovf   = nd[0] && !m_rdy_b;
      if (nd[0] && m_rdy_b) begin
        m_st = (n + 2 > line_free) ? n + 2 : line_free;
        m_push.push_back(n);
        m_start.push_back(m_st);
        m_word.push_back(data_in);
        line_free = m_st + FRM;
      end
      while (m_start.size() > 0 && m_start[0] + FRM <= n) begin
        void'(m_push.pop_front()); void'(m_start.pop_front()); void'(m_word.pop_front());
      end
      #1;
      if (!rst) begin
        check("model tx", w_tx[0], tx_at(n));
        check("model busy", w_busy[0], busy_at(n));
        check("model count", cnt0, cnt_at(n));
        check("model ready", rdy[0], cnt_at(n) < 4);
        check("model overflow", ovf[0], m_ovf);
      end
    end
  end

  typedef struct {
    logic [1:0]  dut;
    logic [7:0]  din;
    int          nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t       vt [9];
  vec_t       cur;
  logic [3:0] bi;
  int         frm_len;
  int         pct [4] = '{5, 30, 60, 95};
  int         exp_cnt3 [6] = '{1, 1, 2, 3, 4, 4};

  task automatic wait_idle(input logic [1:0] sel);
    int k = 0;
    while (w_busy[sel] !== 1'b0 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 1000) check("idle wait timeout", w_busy[sel], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // bits are listed wire-order LSB first: {stop(s), parity, data, start}
    vt[0] = '{2'd0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    vt[1] = '{2'd1, 8'hA5, 11, 12'({1'b1, 1'b0, 8'hA5, 1'b0})};
    vt[2] = '{2'd2, 8'hA5, 12, 12'({2'b11, 1'b1, 8'hA5, 1'b0})};
    vt[3] = '{2'd3, 8'hF3, 7,  12'({1'b1, 5'h13, 1'b0})};
    vt[4] = '{2'd0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0})};
    vt[5] = '{2'd1, 8'h07, 11, 12'({1'b1, 1'b1, 8'h07, 1'b0})};
    vt[6] = '{2'd2, 8'h00, 12, 12'({2'b11, 1'b1, 8'h00, 1'b0})};
    vt[7] = '{2'd2, 8'h01, 12, 12'({2'b11, 1'b0, 8'h01, 1'b0})};
    vt[8] = '{2'd1, 8'hFF, 11, 12'({1'b1, 1'b0, 8'hFF, 1'b0})};

    rst = 1'b1;
    nd = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", w_tx, 4'hF);
    check("reset busy", w_busy, 4'h0);
    check("reset ready", rdy, 4'hF);
    check("reset overflow", ovf, 4'h0);
    check("reset count", {cnt3, cnt2, cnt1, cnt0}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      cur = vt[i];
      frm_len = cur.nbits * CPB;
      wait_idle(cur.dut);
      @(negedge clk);
      data_in = cur.din;
      nd[cur.dut] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("vec%0d busy after push", i), w_busy[cur.dut], 1);
      @(negedge clk) nd[cur.dut] = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d tx idle one cycle", i), w_tx[cur.dut], 1);
      for (int k = 0; k < frm_len; k++) begin
        @(posedge clk); #1;
        bi = 4'(k / CPB);
        check($sformatf("vec%0d tx cycle %0d", i, k), w_tx[cur.dut], cur.bits[bi]);
        if (k == frm_len - 2) check($sformatf("vec%0d busy last stop", i), w_busy[cur.dut], 1);
        if (k == frm_len - 1) check($sformatf("vec%0d busy falls", i), w_busy[cur.dut], 0);
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d tx after frame", i), w_tx[cur.dut], 1);
    end

    // six pushes on consecutive cycles into an idle u0
    wait_idle(2'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      nd[0] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("burst count %0d", i), cnt0, exp_cnt3[i]);
      check($sformatf("burst ready %0d", i), rdy[0], i < 4);
      check($sformatf("burst overflow %0d", i), ovf[0], i == 5);
    end
    @(negedge clk) nd[0] = 1'b0;
    @(posedge clk); #1;
    check("burst overflow pulse ends", ovf[0], 0);
    wait_idle(2'd0);

    // push coinciding with the stop-end pop while two words wait
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = 8'(8'h30 + i);
      nd[0] = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk) nd[0] = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    check("pushpop count before", cnt0, 2);
    @(negedge clk);
    data_in = 8'h33;
    nd[0] = 1'b1;
    @(posedge clk); #1;
    check("pushpop count same edge", cnt0, 2);
    @(negedge clk) nd[0] = 1'b0;
    wait_idle(2'd0);

    // reset in the middle of a frame with three words queued
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = (i == 0) ? 8'h00 : 8'($urandom);
      nd[0] = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk) nd[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midframe tx low before reset", w_tx[0], 0);
    check("midframe count before reset", cnt0, 3);
    rst = 1'b1;
    #1;
    check("async reset tx", w_tx[0], 1);
    check("async reset count", cnt0, 0);
    check("async reset busy", w_busy[0], 0);
    check("async reset ready", rdy[0], 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("no frame after reset", w_busy[0], 0);

    // random bursts of varying density
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        nd[0] = ($urandom_range(0, 99) < pct[ph]);
        data_in = 8'($urandom);
      end
      @(negedge clk) nd[0] = 1'b0;
      wait_idle(2'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
